dtree_feature_loader: RTL

- Upstream front-end for the combinational arrhythmia decision-tree classifiers.
- Accepts feature bytes one per beat over a valid/ready stream and assembles a full feature vector into registers held stable on a parallel bus.
- After a programmable settle time, captures the tree's class output and presents it downstream with a valid/ready handshake.
- One classification per frame; no overlap between frames.

---
 rtl/dtree_feature_loader.sv | 112 +++++++++++
 1 files changed

// File: rtl/dtree_feature_loader.sv
// Front-end for the combinational decision-tree classifiers: assembles a feature
// vector from a byte stream, lets the tree settle, samples the class and hands it on.
module dtree_feature_loader #(
    parameter int NUM_FEAT = 7,
    parameter int FEAT_W   = 8,
    parameter int CLASS_W  = 5,
    parameter int SETTLE   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FEAT_W-1:0]          in_data,
    input  logic                       in_first,
    output logic [NUM_FEAT*FEAT_W-1:0] feat_bus,
    input  logic [CLASS_W-1:0]         class_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CLASS_W-1:0]         class_out,
    output logic                       frame_err
);

    localparam int               CNT_W       = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT   = CNT_W'(NUM_FEAT - 1);
    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE);

    typedef enum logic [1:0] {
        LOAD,
        EVAL,
        HOLD
    } state_t;

    state_t                      r_state;
    logic [CNT_W-1:0]            r_cnt;
    logic [3:0]                  r_settle;
    logic [NUM_FEAT*FEAT_W-1:0]  r_feat;
    logic [CLASS_W-1:0]          r_class;
    logic                        r_out_valid;
    logic                        r_frame_err;

    logic                        w_in_ready;
    logic                        w_accept;
    logic [CNT_W-1:0]            w_wr_slot;
    logic                        w_last;

    assign w_in_ready = (r_state == LOAD) && !rst;
    assign w_accept   = w_in_ready && in_valid;
    // A resync marker always lands in slot 0, even on what would have been the final beat.
    assign w_wr_slot  = in_first ? '0 : r_cnt;
    assign w_last     = (w_wr_slot == LAST_SLOT);

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of statement order.
    // NOTE: the feature slots are individual flops, not a RAM, so clearing them on
    // reset is cheap and keeps the tree inputs defined from the first cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= LOAD;
            r_cnt       <= '0;
            r_settle    <= '0;
            r_feat      <= '0;
            r_class     <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        for (int i = 0; i < NUM_FEAT; i++) begin
                            if (w_wr_slot == CNT_W'(i)) begin
                                r_feat[i*FEAT_W +: FEAT_W] <= in_data;
                            end
                        end
                        r_frame_err <= in_first && (r_cnt != '0);
                        if (w_last) begin
                            r_cnt    <= '0;
                            r_settle <= SETTLE_INIT;
                            r_state  <= EVAL;
                        end else begin
                            r_cnt <= w_wr_slot + CNT_W'(1);
                        end
                    end
                end
                EVAL: begin
                    // Sampling on the edge after the counter hits zero gives SETTLE+1 edges of settle.
                    if (r_settle == '0) begin
                        r_class     <= class_in;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else begin
                        r_settle <= r_settle - 4'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= LOAD;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign feat_bus  = r_feat;
    assign out_valid = r_out_valid;
    assign class_out = r_class;
    assign frame_err = r_frame_err;

endmodule
